axi_stream_prbs_source: RTL and testbench

//  PRBS test-pattern source that feeds the stream comparator.
//  - Emits a Galois-LFSR word sequence on an AXI-Stream master.
//  - Supports finite or unbounded runs, inter-word idle gaps, and single-word error injection.
//  - Two instances with the same SEED drive the two paths under test; injection checks mismatch detection.

---
 rtl/axi_stream_prbs_source_if.sv | 24 ++
 rtl/axi_stream_prbs_source.sv | 153 +++++++++++++++
 tb/tb_axi_stream_prbs_source.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_prbs_source_if.sv
// AXI-Stream master/slave bundle used by the PRBS pattern source.
// Carries valid/ready/data/last for one stream direction.
interface axi_stream_prbs_source_if #(
    parameter int DATA_BITS = 32
);
    logic                 m_tvalid;
    logic                 m_tready;
    logic [DATA_BITS-1:0] m_tdata;
    logic                 m_tlast;

    modport master (
        output m_tvalid,
        output m_tdata,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tvalid,
        input  m_tdata,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/axi_stream_prbs_source.sv
// Galois-LFSR PRBS word source on an AXI-Stream master.
// Finite/unbounded runs, idle gaps between words, single-word error tagging.
module axi_stream_prbs_source #(
    parameter int                   DATA_BITS  = 32,
    parameter int                   COUNT_BITS = 32,
    parameter logic [DATA_BITS-1:0] SEED       = 32'h00000001,
    parameter logic [DATA_BITS-1:0] TAPS       = 32'h80200003
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic [COUNT_BITS-1:0]         word_count,
    input  logic [7:0]                    gap_cycles,
    input  logic                          inject_error,
    axi_stream_prbs_source_if.master      axis,
    output logic                          busy,
    output logic                          done,
    output logic [COUNT_BITS-1:0]         words_sent
);

    localparam logic [DATA_BITS-1:0] SEED_EFF =
        (SEED == '0) ? DATA_BITS'(1) : SEED;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_BITS-1:0]  lfsr_q, lfsr_d;
    logic [COUNT_BITS-1:0] sent_q, sent_d;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic [7:0]            gap_len_q, gap_len_d;
    logic [7:0]            gap_cnt_q, gap_cnt_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  err_pend_q, err_pend_d;
    logic                  corrupt_q, corrupt_d;
    logic                  done_q, done_d;

    logic                  valid;
    logic                  xfer;
    logic                  last;
    logic                  stop_eff;
    logic                  err_next;
    logic [DATA_BITS-1:0]  lfsr_adv;

    assign valid    = (state_q == SEND);
    assign xfer     = valid && axis.m_tready;
    assign last     = (count_q != '0) && ((sent_q + COUNT_BITS'(1)) == count_q);
    assign stop_eff = stop_pend_q | stop;
    assign lfsr_adv = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        sent_d      = sent_q;
        count_d     = count_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
        corrupt_d   = corrupt_q;
        done_d      = 1'b0;
        stop_pend_d = (state_q != IDLE) ? stop_eff : 1'b0;

        // A pulse arriving while a tag is outstanding merges into it.
        err_next = err_pend_q | inject_error;
        if (xfer && corrupt_q) begin
            err_next = 1'b0;
        end
        err_pend_d = err_next;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SEND;
                    lfsr_d      = SEED_EFF;
                    sent_d      = '0;
                    count_d     = word_count;
                    gap_len_d   = gap_cycles;
                    corrupt_d   = err_next;
                    stop_pend_d = 1'b0;
                end
            end
            SEND: begin
                if (xfer) begin
                    sent_d    = sent_q + COUNT_BITS'(1);
                    lfsr_d    = lfsr_adv;
                    corrupt_d = 1'b0;
                    if (last || stop_eff) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                    end else if (gap_len_q != 8'd0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_len_q;
                    end else begin
                        corrupt_d = err_next;
                    end
                end
            end
            GAP: begin
                if (stop_eff) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                end else if (gap_cnt_q <= 8'd1) begin
                    state_d   = SEND;
                    corrupt_d = err_next;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED_EFF;
            sent_q      <= '0;
            count_q     <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            err_pend_q  <= 1'b0;
            corrupt_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            sent_q      <= sent_d;
            count_q     <= count_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_pend_q <= stop_pend_d;
            err_pend_q  <= err_pend_d;
            corrupt_q   <= corrupt_d;
            done_q      <= done_d;
        end
    end

    assign axis.m_tvalid = valid;
    assign axis.m_tdata  = valid ? (lfsr_q ^ DATA_BITS'(corrupt_q)) : '0;
    assign axis.m_tlast  = valid && last;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign words_sent    = sent_q;

endmodule

// File: tb/tb_axi_stream_prbs_source.sv
// Bench for axi_stream_prbs_source: word-index model of the PRBS stream
// checked every cycle, plus directed scenarios with literal expectations.
module tb_axi_stream_prbs_source;

    localparam logic [31:0] TB_TAPS = 32'h80200003;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        inject_a;
    logic        ready;
    logic [31:0] word_count;
    logic [7:0]  gap_cycles;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] sent_a, sent_b;

    axi_stream_prbs_source_if #(.DATA_BITS(32)) ax_a ();
    axi_stream_prbs_source_if #(.DATA_BITS(32)) ax_b ();

    assign ax_a.m_tready = ready;
    assign ax_b.m_tready = ready;

    axi_stream_prbs_source dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .word_count(word_count), .gap_cycles(gap_cycles),
        .inject_error(inject_a), .axis(ax_a),
        .busy(busy_a), .done(done_a), .words_sent(sent_a)
    );

    axi_stream_prbs_source dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .word_count(word_count), .gap_cycles(gap_cycles),
        .inject_error(1'b0), .axis(ax_b),
        .busy(busy_b), .done(done_b), .words_sent(sent_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // n-th word of the pattern, counted from the seed.
    function automatic logic [31:0] prbs_word(input int n);
        logic [31:0] s;
        s = 32'h1;
        for (int i = 0; i < n; i++) begin
            s = (s >> 1) ^ (s[0] ? TB_TAPS : 32'h0);
        end
        return s;
    endfunction

    // Model state, owned by the monitor.
    int          m_idx = 0;
    logic [31:0] m_count = '0;
    bit          stop_flag = 0;
    bit          done_exp = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    bit          rst_prev = 0;
    int          mism = 0;
    int          bad_idx = -1;
    logic [31:0] got [0:255];
    bit          m_xfer, m_last, m_stopf, m_end;
    logic [31:0] m_exp;

    always @(negedge clk) begin
        if (rst) begin
            if (rst_prev) begin
                chk("rst_tvalid", 64'(ax_a.m_tvalid), 64'(0));
                chk("rst_tdata", 64'(ax_a.m_tdata), 64'(0));
                chk("rst_tlast", 64'(ax_a.m_tlast), 64'(0));
                chk("rst_busy", 64'(busy_a), 64'(0));
                chk("rst_done", 64'(done_a), 64'(0));
                chk("rst_sent", 64'(sent_a), 64'(0));
            end
            m_idx      = 0;
            stop_flag  = 0;
            done_exp   = 0;
            prev_stall = 0;
        end else begin
            m_last = (m_count != 0) && (32'(m_idx + 1) == m_count);
            chk("done", 64'(done_a), 64'(done_exp));
            chk("words_sent", 64'(sent_a), 64'(m_idx));
            chk("b_lockstep", {29'd0, busy_b, done_b, ax_b.m_tlast, sent_b},
                {29'd0, busy_a, done_a, ax_a.m_tlast, sent_a});
            if (prev_stall) begin
                chk("hold_tvalid", 64'(ax_a.m_tvalid), 64'(1));
                chk("hold_tdata", 64'(ax_a.m_tdata), 64'(prev_data));
                chk("hold_tlast", 64'(ax_a.m_tlast), 64'(prev_last));
            end
            if (ax_a.m_tvalid) begin
                m_exp = prbs_word(m_idx) ^ ((m_idx == bad_idx) ? 32'h1 : 32'h0);
                chk("tdata", 64'(ax_a.m_tdata), 64'(m_exp));
                chk("tlast", 64'(ax_a.m_tlast), 64'(m_last));
            end
            if (ax_a.m_tvalid && ax_b.m_tvalid &&
                ax_a.m_tdata != ax_b.m_tdata) begin
                mism++;
                chk("ab_diff", 64'(ax_a.m_tdata ^ ax_b.m_tdata), 64'(1));
            end
            m_xfer    = ax_a.m_tvalid && ready;
            m_stopf   = stop_flag || (stop && busy_a);
            m_end     = busy_a && ((m_xfer && (m_last || m_stopf)) ||
                                   (!ax_a.m_tvalid && m_stopf));
            done_exp  = m_end;
            stop_flag = m_end ? 1'b0 : m_stopf;
            prev_stall = ax_a.m_tvalid && !ready;
            prev_data  = ax_a.m_tdata;
            prev_last  = ax_a.m_tlast;
            if (m_xfer) begin
                got[m_idx % 256] = ax_a.m_tdata;
                m_idx++;
            end
            if (start && !busy_a) begin
                m_idx   = 0;
                m_count = word_count;
            end
        end
        rst_prev = rst;
    end

    task automatic pulse_start(input logic [31:0] cnt, input logic [7:0] gap);
        @(posedge clk); #1;
        word_count = cnt;
        gap_cycles = gap;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_a && n < budget);
        chk(name, 64'(done_a), 64'(1));
    endtask

    logic [6:0] pat;
    int         n, m0;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; inject_a = 1'b0;
        ready = 1'b1; word_count = '0; gap_cycles = '0;
        for (int i = 0; i < 256; i++) got[i] = '0;

        chk("model_w0", 64'(prbs_word(0)), 64'h00000001);
        chk("model_w1", 64'(prbs_word(1)), 64'h80200003);
        chk("model_w2", 64'(prbs_word(2)), 64'hC0300002);
        chk("model_w3", 64'(prbs_word(3)), 64'h60180001);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Finite back-to-back run.
        pulse_start(32'd4, 8'd0);
        wait_done(20, "t1_done");
        chk("t1_sent", 64'(sent_a), 64'(4));
        chk("t1_w0", 64'(got[0]), 64'h00000001);
        chk("t1_w1", 64'(got[1]), 64'h80200003);
        chk("t1_w2", 64'(got[2]), 64'hC0300002);
        chk("t1_w3", 64'(got[3]), 64'h60180001);

        // Gapped run; stop together with start in IDLE is ignored.
        @(posedge clk); #1;
        word_count = 32'd3; gap_cycles = 8'd2; start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        pat = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            pat = {pat[5:0], ax_a.m_tvalid};
        end
        chk("t2_valid_pat", 64'(pat), 64'(7'b1001001));
        wait_done(10, "t2_done");
        chk("t2_sent", 64'(sent_a), 64'(3));
        chk("t2_w2", 64'(got[2]), 64'hC0300002);

        // Random backpressure, with a start pulse mid-run that must be ignored.
        ready = 1'b1;
        pulse_start(32'd100, 8'd0);
        for (n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            ready = ($urandom_range(0, 9) < 3);
            start = (n == 20);
            @(negedge clk);
            if (done_a) break;
        end
        start = 1'b0;
        chk("t3_done", 64'(done_a), 64'(1));
        chk("t3_sent", 64'(sent_a), 64'(100));
        chk("t3_w99", 64'(got[99]), 64'(prbs_word(99)));
        @(posedge clk); #1;
        ready = 1'b1;

        // Error injection while word 2 is presented lands on word 3.
        m0 = mism;
        bad_idx = 2;
        pulse_start(32'd6, 8'd0);
        for (n = 0; n < 20; n++) begin
            if (sent_a == 32'd1) begin
                inject_a = 1'b1;
                @(posedge clk); #1;
                inject_a = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        wait_done(20, "t4_done");
        chk("t4_mismatches", 64'(mism - m0), 64'(1));
        chk("t4_w2", 64'(got[2]), 64'hC0300003);
        chk("t4_w3", 64'(got[3]), 64'h60180001);
        @(posedge clk); #1;
        bad_idx = -1;

        // Unbounded run stopped while word 11 is stalled.
        pulse_start(32'd0, 8'd0);
        n = 0;
        while (sent_a != 32'd10 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        ready = 1'b0;
        chk("t5_reach10", 64'(sent_a), 64'(10));
        repeat (2) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("t5_still_busy", 64'(busy_a), 64'(1));
        ready = 1'b1;
        wait_done(10, "t5_done");
        chk("t5_sent", 64'(sent_a), 64'(11));
        @(negedge clk);
        chk("t5_idle", 64'(busy_a), 64'(0));

        // Reset in the middle of a run, then a fresh run.
        pulse_start(32'd0, 8'd0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("t6_valid_low", 64'(ax_a.m_tvalid), 64'(0));
        pulse_start(32'd3, 8'd0);
        wait_done(20, "t6_done");
        chk("t6_sent", 64'(sent_a), 64'(3));
        chk("t6_w0", 64'(got[0]), 64'h00000001);
        chk("t6_w1", 64'(got[1]), 64'h80200003);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
